// File: rtl/status_snapshot.sv
`timescale 1ns/1ps
// status_snapshot: captures a coherent image of live status words plus a
// sequence number and timestamp, then commits it to the read-only register
// image with a one-cycle write strobe. Captures come from a periodic timer or
// a manual trigger; the commit is held off while a UART read is in progress.
module status_snapshot #(
  parameter  int WORD_WIDTH   = 8,
  parameter  int REG_WIDTH    = 4,
  parameter  int REG_DEPTH_RO = 16,
  parameter  int N_STATUS     = 12,
  localparam int DW           = WORD_WIDTH * REG_WIDTH
) (
  input  logic                            clk,
  input  logic                            i_reset_n,
  input  logic [N_STATUS-1:0][DW-1:0]     i_status,
  input  logic                            i_enable,
  input  logic [DW-1:0]                   i_period,
  input  logic                            i_trigger,
  input  logic                            i_read_active,
  input  logic                            i_clear_overrun,
  output logic [REG_DEPTH_RO-1:0][DW-1:0] o_mem_ro,
  output logic                            o_wro_en,
  output logic                            o_busy,
  output logic                            o_overrun
);

  typedef enum logic {S_IDLE, S_COMMIT} state_t;

  state_t                         r_state;
  logic [DW-1:0]                  r_ts;
  logic [DW-1:0]                  r_timer;
  logic [DW-1:0]                  r_seq;
  logic                           r_pending;
  logic [REG_DEPTH_RO-1:0][DW-1:0] r_shadow;
  logic [REG_DEPTH_RO-1:0][DW-1:0] r_mem_ro;
  logic                           r_wro_en;
  logic                           r_overrun;

  logic                           w_timer_on;
  logic                           w_tick;
  logic                           w_req;
  logic                           w_drop;
  logic [REG_DEPTH_RO-1:0][DW-1:0] w_capture;

  // The >= compare makes a period lowered below the current count tick at once.
  assign w_timer_on = i_enable && (i_period != '0);
  assign w_tick     = w_timer_on && (r_timer >= (i_period - DW'(1)));
  assign w_req      = w_tick | i_trigger;
  // A second request arriving while one is already queued behind a commit is lost.
  assign w_drop     = (r_state == S_COMMIT) && w_req && r_pending;

  // Image as it would be latched this edge: seq, pre-increment ts, status, zero fill.
  always_comb begin
    w_capture    = '0;
    w_capture[0] = r_seq;
    w_capture[1] = r_ts;
    for (int k = 0; k < N_STATUS; k++) w_capture[2+k] = i_status[k];
  end

  // Free-running timestamp.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) r_ts <= '0;
    else            r_ts <= r_ts + DW'(1);
  end

  // Periodic timer: held at zero when disabled, restarts on each tick.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n)       r_timer <= '0;
    else if (!w_timer_on) r_timer <= '0;
    else if (w_tick)      r_timer <= '0;
    else                  r_timer <= r_timer + DW'(1);
  end

  // Capture/commit FSM with one-deep request queue and sticky overrun flag.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_seq     <= '0;
      r_pending <= 1'b0;
      r_shadow  <= '0;
      r_mem_ro  <= '0;
      r_wro_en  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_wro_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req || r_pending) begin
            r_shadow  <= w_capture;
            r_pending <= 1'b0;
            r_state   <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (!i_read_active) begin
            r_mem_ro <= r_shadow;
            r_wro_en <= 1'b1;
            r_seq    <= r_seq + DW'(1);
            r_state  <= S_IDLE;
          end
          if (w_req && !r_pending) r_pending <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
      // Setting wins over a same-cycle clear so no drop goes unreported.
      if (w_drop)               r_overrun <= 1'b1;
      else if (i_clear_overrun) r_overrun <= 1'b0;
    end
  end

  assign o_mem_ro  = r_mem_ro;
  assign o_wro_en  = r_wro_en;
  assign o_busy    = (r_state == S_COMMIT);
  assign o_overrun = r_overrun;

endmodule
